// File: rtl/c3aibadapt_txasync_ssr_serializer_if.sv
// Signal bundle between the TX async SSR frame engine and its capture stage / serial consumer.
// The master modport is the frame engine; the slave modport is the attached logic.
interface c3aibadapt_txasync_ssr_serializer_if #(
    parameter int unsigned WIDTH = 3
);
    logic             tx_async_ssr_enable;
    logic [WIDTH-1:0] tx_async_hssi_fabric_ssr_data;
    logic             tx_async_hssi_fabric_ssr_load;
    logic             tx_async_ssr_sdata;
    logic             tx_async_ssr_sload;
    logic             tx_async_ssr_busy;

    modport master (
        input  tx_async_ssr_enable,
        input  tx_async_hssi_fabric_ssr_data,
        output tx_async_hssi_fabric_ssr_load,
        output tx_async_ssr_sdata,
        output tx_async_ssr_sload,
        output tx_async_ssr_busy
    );

    modport slave (
        output tx_async_ssr_enable,
        output tx_async_hssi_fabric_ssr_data,
        input  tx_async_hssi_fabric_ssr_load,
        input  tx_async_ssr_sdata,
        input  tx_async_ssr_sload,
        input  tx_async_ssr_busy
    );
endinterface

// File: rtl/c3aibadapt_txasync_ssr_serializer.sv
// Slow shift register frame engine: pulses load to the capture bits, samples the word after the
// capture latency, shifts it out LSB-first with a bit-0 marker, then idles for a gap.
module c3aibadapt_txasync_ssr_serializer #(
    parameter int unsigned WIDTH      = 3,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic tx_clock_async_tx_osc_clk,
    input  logic tx_reset_async_tx_osc_clk_rst_n,
    c3aibadapt_txasync_ssr_serializer_if.master bus
);
    localparam int unsigned MAX_WL     = (WIDTH > LOAD_LAT) ? WIDTH : LOAD_LAT;
    localparam int unsigned MAX_WLG    = (MAX_WL > GAP_CYCLES) ? MAX_WL : GAP_CYCLES;
    localparam int unsigned CNT_MAX    = (MAX_WLG > 2) ? MAX_WLG : 2;
    localparam int unsigned CW         = $clog2(CNT_MAX);
    localparam int unsigned GAP_RELOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_SHIFT = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t           state, state_n, ret_state;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             load_q, sdata_q, sload_q, busy_q;
    logic             load_n, sdata_n, sload_n, busy_n;

    // State, counter, shift register and registered outputs.
    always_ff @(posedge tx_clock_async_tx_osc_clk or negedge tx_reset_async_tx_osc_clk_rst_n) begin
        if (!tx_reset_async_tx_osc_clk_rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            shreg   <= '0;
            load_q  <= 1'b0;
            sdata_q <= 1'b0;
            sload_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shreg   <= shreg_n;
            load_q  <= load_n;
            sdata_q <= sdata_n;
            sload_q <= sload_n;
            busy_q  <= busy_n;
        end
    end

    // Next state; outputs are decoded from the next state so they appear in the state's own cycle.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shreg_n   = shreg;
        ret_state = bus.tx_async_ssr_enable ? S_LOAD : S_IDLE;

        case (state)
            S_IDLE: begin
                if (bus.tx_async_ssr_enable) begin
                    state_n = S_LOAD;
                    cnt_n   = '0;
                end
            end
            S_LOAD: begin
                state_n = S_WAIT;
                cnt_n   = CW'(LOAD_LAT - 1);
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_n = S_SHIFT;
                    cnt_n   = CW'(WIDTH - 1);
                    shreg_n = bus.tx_async_hssi_fabric_ssr_data;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_SHIFT: begin
                shreg_n = shreg >> 1;
                if (cnt == '0) begin
                    if (GAP_CYCLES > 0) begin
                        state_n = S_GAP;
                        cnt_n   = CW'(GAP_RELOAD);
                    end else begin
                        state_n = ret_state;
                        cnt_n   = '0;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    state_n = ret_state;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase

        load_n  = (state_n == S_LOAD);
        busy_n  = (state_n != S_IDLE);
        sload_n = (state_n == S_SHIFT) && (state != S_SHIFT);
        sdata_n = (state_n == S_SHIFT) && shreg_n[0];
    end

    assign bus.tx_async_hssi_fabric_ssr_load = load_q;
    assign bus.tx_async_ssr_sdata            = sdata_q;
    assign bus.tx_async_ssr_sload            = sload_q;
    assign bus.tx_async_ssr_busy             = busy_q;
endmodule
